// File: rtl/regfile_dump_tx_if.sv
// Byte-wide valid/ready link from the register dump engine to a transmitter.
// The engine drives data/valid as master; the transmitter answers with ready.
interface regfile_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_tx.sv
// Snapshots the 32x32 register file on start and streams it as a framed byte sequence:
// header, 128 data bytes (reg 0..31, MSB first), then an XOR checksum of the data bytes.
module regfile_dump_tx #(
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1023:0]         regs_flat,
  regfile_dump_tx_if.master     tx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CSUM
  } state_t;

  state_t        state;
  logic [1023:0] snap;
  logic [4:0]    reg_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;

  logic          accept;
  logic          last_data;
  logic [4:0]    nxt_reg;
  logic [1:0]    nxt_byte;
  logic [7:0]    cur_data;
  logic [7:0]    nxt_data;

  // reg_idx/byte_idx point at the byte currently offered; {reg,byte,000} is its bit offset
  always_comb begin
    accept    = tx.tx_valid && tx.tx_ready;
    last_data = (reg_idx == 5'd31) && (byte_idx == 2'd0);
    nxt_byte  = byte_idx - 2'd1;
    nxt_reg   = reg_idx;
    if (byte_idx == 2'd0) begin
      nxt_reg = reg_idx + 5'd1;
    end
    cur_data  = snap[{reg_idx, byte_idx, 3'b000} +: 8];
    nxt_data  = snap[{nxt_reg, nxt_byte, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      snap        <= '0;
      reg_idx     <= 5'd0;
      byte_idx    <= 2'd0;
      csum        <= 8'h00;
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap        <= regs_flat;
            csum        <= 8'h00;
            reg_idx     <= 5'd0;
            byte_idx    <= 2'd3;
            tx.tx_data  <= START_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= HEADER;
          end
        end
        HEADER: begin
          if (accept) begin
            tx.tx_data <= cur_data;
            state      <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum ^ tx.tx_data;
            // The checksum goes out right behind the last data byte, so fold it in here
            if (last_data) begin
              tx.tx_data <= csum ^ tx.tx_data;
              state      <= CSUM;
            end else begin
              tx.tx_data <= nxt_data;
              reg_idx    <= nxt_reg;
              byte_idx   <= nxt_byte;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_dump_tx.md
# regfile_dump_tx

Debug read-out engine for the 32×32 register file. On a start pulse it snapshots all 32 register debug outputs and streams them as a framed byte sequence to a byte-wide transmitter (UART TX or similar) over a valid/ready handshake. The register file exposes its contents. This block consumes those contents and sends them off-chip.

## Interface
Parameters:
- `START_BYTE`, default `8'hA5`. Frame header byte.

Ports:
- `clk`, input, 1 bit. Rising-edge clock.
- `reset`, input, 1 bit. Asynchronous, active-high reset.
- `start`, input, 1 bit. Dump request. Sampled only in IDLE.
- `regs_flat`, input, 1024 bits. Register file debug outputs. Bits `[32*i+31:32*i]` carry register i, for i = 0..31.
- `tx_data`, output, 8 bits. Byte offered to the transmitter.
- `tx_valid`, output, 1 bit. `tx_data` is valid.
- `tx_ready`, input, 1 bit. The transmitter accepts the byte when `tx_valid && tx_ready` at a rising edge.
- `busy`, output, 1 bit. A frame is in progress.
- `done`, output, 1 bit. One-cycle pulse after the final byte is accepted.

## Operation
- Frame layout is 130 bytes, sent in this order:
  - `START_BYTE`.
  - Registers 0..31, each as 4 bytes, MSB first: bits [31:24], [23:16], [15:8], [7:0].
  - Checksum byte: XOR of the 128 data bytes. The header is excluded.
- Snapshot: on the edge where `start` is accepted, all 1024 bits of `regs_flat` are latched into an internal buffer. Later register writes do not affect the frame in flight. The register file updates on the falling edge, so the value captured is the one stable at the rising edge.
- Counters:
  - `reg_idx` is 5 bits, 0..31.
  - `byte_idx` is 2 bits, 3..0.
  - The checksum accumulator is 8 bits. It is cleared at start and XORs each data byte in as that byte is accepted.
- FSM states and transitions:
  - IDLE → HEADER when `start` is high.
  - HEADER → DATA when the header byte is accepted.
  - DATA advances `byte_idx`, then `reg_idx`, on each accept. After the accept of reg 31 byte 0, it goes to CSUM.
  - CSUM → IDLE when the checksum byte is accepted. `done` is pulsed on that transition.
- `tx_data` and `tx_valid` are registered outputs. Once `tx_valid` is raised, it and `tx_data` hold stable until the byte is accepted. The block never withdraws `tx_valid` before acceptance.
- `start` while `busy` is ignored, not queued.
- `busy` is 1 in HEADER, DATA and CSUM, and 0 in IDLE.

## Timing
- Reset values: state IDLE, `tx_valid` 0, `tx_data` 8'h00, `busy` 0, `done` 0, counters 0, checksum 0, snapshot buffer 0.
- Reset asserted mid-frame: all of the above take effect immediately, asynchronously. The frame is abandoned with no `done` pulse. After reset is released, nothing is sent until a new `start`.
- Start timing: with `start` high at edge E0, `tx_valid` = 1 and `tx_data` = `START_BYTE` from E0, and `busy` = 1 from E0.
- Latency with `tx_ready` held high:
  - One byte is accepted per edge, E1 through E130.
  - The checksum byte is accepted at E130.
  - At E130, `tx_valid` and `busy` fall and `done` rises, high for exactly one cycle.
- With `tx_ready` low, the block stalls indefinitely with no timeout. Each cycle `tx_ready` is low adds one cycle to the frame.
- `start` high during the `done` cycle is accepted at the next edge, since the state is already IDLE. Back-to-back frames are therefore separated by zero idle bytes.
- `done` and `start` are never both acted on in the same edge.

## Test plan
- Register i = i (0..31), `tx_ready` always 1, single `start` pulse:
  - Output is A5, 00 00 00 00, 00 00 00 01, …, 00 00 00 1F.
  - The checksum byte is 8'h00.
  - `done` pulses exactly at E130 +1 cycle, and `busy` is high for 130 cycles.
- Register 5 = 32'hDEADBEEF, all others 0:
  - Bytes 21..24 (1-based, after the header) are DE AD BE EF.
  - The checksum is 8'h22.
- Backpressure: `tx_ready` random, at about 30% duty.
  - The byte sequence is identical to the first test.
  - `tx_data` never changes while `tx_valid && !tx_ready`.
  - `done` occurs only after the 130th accept.
- Snapshot isolation: change `regs_flat` (register 0 → FFFFFFFF) one cycle after `start`.
  - The frame still sends the pre-change values, with checksum unchanged.
- `start` re-pulsed at byte 50: ignored, and the frame completes normally. `start` held high through `done`: a second frame begins at the next edge.
- Assert `reset` at byte 70:
  - `tx_valid`, `busy` and `done` drop to 0 immediately, with no `done` pulse.
  - A new `start` after release yields a complete, correct 130-byte frame.
